// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue request generator.
package pq_pkg;

    localparam int unsigned PQ_KEY_W      = 16;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic {
        PQ_ADD    = 1'b0,
        PQ_REMOVE = 1'b1
    } pq_op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_CHK  = 3'd1,
        FILL      = 3'd2,
        FILL_GAP  = 3'd3,
        DRAIN_CHK = 3'd4,
        DRAIN     = 3'd5,
        DRAIN_GAP = 3'd6
    } gen_state_t;

endpackage

// File: rtl/pq_req_gen_if.sv
// Request channel and status flags between the generator and the priority queue.
interface pq_req_gen_if;
    import pq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    pq_op_t              req_op;
    logic [PQ_KEY_W-1:0] req_key;
    logic                pq_full;
    logic                pq_empty;

    modport master (
        output req_valid, req_op, req_key,
        input  req_ready, pq_full, pq_empty
    );

    modport slave (
        input  req_valid, req_op, req_key,
        output req_ready, pq_full, pq_empty
    );

endinterface

// File: rtl/pq_lfsr16.sv
// 16-bit right-shifting Galois LFSR key source; a zero seed would lock up, so it becomes 1.
module pq_lfsr16
    import pq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] seed_safe_c;

    assign seed_safe_c = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= seed_safe_c;
        end else if (adv) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/pq_req_gen.sv
// Fill/drain stimulus generator: issues LFSR-keyed adds until full, then removes until empty.
module pq_req_gen
    import pq_pkg::*;
#(
    parameter int unsigned KEY_W      = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    pq_req_gen_if.master                 bus,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic [7:0]                   round_cnt
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    gen_state_t       state_q, state_d;
    logic             req_valid_q, req_valid_d;
    pq_op_t           req_op_q, req_op_d;
    logic [KEY_W-1:0] req_key_q, req_key_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] fill_d;
    logic [7:0]       round_d;
    logic             busy_d;
    logic             xfer_c;
    logic             lfsr_adv_c;
    logic [15:0]      lfsr_val;

    pq_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv_c),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    assign xfer_c        = req_valid_q & bus.req_ready;
    assign bus.req_valid = req_valid_q;
    assign bus.req_op    = req_op_q;
    assign bus.req_key   = PQ_KEY_W'(req_key_q);

    // Next-state and next-output logic; request fields only change while no request is pending.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_op_d    = req_op_q;
        req_key_d   = req_key_q;
        gap_d       = gap_q;
        fill_d      = fill_cnt;
        round_d     = round_cnt;
        lfsr_adv_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = FILL_CHK;
            end
            FILL_CHK: begin
                if (bus.pq_full || fill_cnt == CNT_W'(DEPTH)) begin
                    state_d = DRAIN_CHK;
                end else begin
                    req_valid_d = 1'b1;
                    req_op_d    = PQ_ADD;
                    req_key_d   = KEY_W'(lfsr_val);
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (xfer_c) begin
                    req_valid_d = 1'b0;
                    lfsr_adv_c  = 1'b1;
                    gap_d       = '0;
                    if (fill_cnt < CNT_W'(DEPTH)) fill_d = fill_cnt + CNT_W'(1);
                    state_d = (GAP_CYCLES == 0) ? FILL_CHK : FILL_GAP;
                end
            end
            FILL_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    gap_d   = '0;
                    state_d = FILL_CHK;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DRAIN_CHK: begin
                if (bus.pq_empty || fill_cnt == '0) begin
                    round_d = round_cnt + 8'd1;
                    if (bus.pq_empty) fill_d = '0;
                    state_d = start ? FILL_CHK : IDLE;
                end else begin
                    req_valid_d = 1'b1;
                    req_op_d    = PQ_REMOVE;
                    req_key_d   = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer_c) begin
                    req_valid_d = 1'b0;
                    gap_d       = '0;
                    if (fill_cnt != '0) fill_d = fill_cnt - CNT_W'(1);
                    state_d = (GAP_CYCLES == 0) ? DRAIN_CHK : DRAIN_GAP;
                end
            end
            DRAIN_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    gap_d   = '0;
                    state_d = DRAIN_CHK;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_op_q    <= PQ_ADD;
            req_key_q   <= '0;
            gap_q       <= '0;
            busy        <= 1'b0;
            fill_cnt    <= '0;
            round_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_op_q    <= req_op_d;
            req_key_q   <= req_key_d;
            gap_q       <= gap_d;
            busy        <= busy_d;
            fill_cnt    <= fill_d;
            round_cnt   <= round_d;
        end
    end

endmodule

// File: tb/tb_pq_req_gen.sv
// Directed bench for pq_req_gen: fill/drain sequencing, backpressure, early full, start drop, async reset.
module tb_pq_req_gen;
    import pq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       full = 1'b0;
    logic       busy;
    logic [2:0] fill_cnt;
    logic [7:0] round_cnt;

    int n_run  = 0;
    int n_fail = 0;

    // Transfer log filled by the monitor; tests index it relative to a per-test base.
    int          log_n = 0;
    int          cyc = 0;
    logic        log_op   [256];
    logic [15:0] log_key  [256];
    int          log_cyc  [256];
    logic [2:0]  log_fill [256];

    pq_req_gen_if bus ();

    assign bus.req_ready = ready;
    assign bus.pq_full   = full;
    assign bus.pq_empty  = (fill_cnt == 3'd0);

    pq_req_gen #(
        .KEY_W      (16),
        .DEPTH      (4),
        .GAP_CYCLES (2),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .fill_cnt  (fill_cnt),
        .round_cnt (round_cnt)
    );

    always #5 clk = ~clk;

    // Inputs only change at negedge, so pre-edge values here are stable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) begin
            log_op[log_n[7:0]]   <= bus.req_op;
            log_key[log_n[7:0]]  <= bus.req_key;
            log_cyc[log_n[7:0]]  <= cyc;
            log_fill[log_n[7:0]] <= fill_cnt;
            log_n                <= log_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int k = 0;
        while (log_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(log_n >= target), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!bus.req_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(bus.req_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    localparam logic [15:0] EXP_KEYS [5] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E};

    initial begin
        int base;

        // Basic fill, drain and loop
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(bus.req_valid), 32'd0);
        check("rst_op",    32'(bus.req_op),    32'd0);
        check("rst_key",   32'(bus.req_key),   32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_fill",  32'(fill_cnt),      32'd0);
        check("rst_round", 32'(round_cnt),     32'd0);
        base  = log_n;
        start = 1'b1;
        @(negedge clk);
        check("lat_valid_1", 32'(bus.req_valid), 32'd0);
        check("lat_busy_1",  32'(busy),          32'd1);
        @(negedge clk);
        check("lat_valid_2", 32'(bus.req_valid), 32'd1);
        check("lat_key_2",   32'(bus.req_key),   32'hACE1);
        wait_log(base + 9, 200, "fill_drain_to");
        check("loop_round", 32'(round_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_op%0d", i),  32'(log_op[base+i]),  32'd0);
            check($sformatf("fill_key%0d", i), 32'(log_key[base+i]), 32'(EXP_KEYS[i]));
        end
        for (int i = 1; i < 4; i++)
            check($sformatf("fill_gap%0d", i), 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd4);
        check("fill_full_cnt", 32'(log_fill[base+4]), 32'd4);
        for (int i = 4; i < 8; i++) begin
            check($sformatf("drain_op%0d", i),  32'(log_op[base+i]),  32'd1);
            check($sformatf("drain_key%0d", i), 32'(log_key[base+i]), 32'd0);
        end
        check("loop_op",  32'(log_op[base+8]),  32'd0);
        check("loop_key", 32'(log_key[base+8]), 32'(EXP_KEYS[4]));

        // Backpressure on the second add
        do_reset();
        ready = 1'b1;
        full  = 1'b0;
        base  = log_n;
        start = 1'b1;
        wait_log(base + 1, 50, "bp_first_to");
        ready = 1'b0;
        wait_valid(50, "bp_valid_to");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(bus.req_valid), 32'd1);
            check($sformatf("bp_key%0d", i),   32'(bus.req_key),   32'hE270);
            if (i < 4) @(negedge clk);
        end
        check("bp_no_xfer", 32'(log_n - base), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_now",  32'(log_n - base),    32'd2);
        check("bp_xfer_key",  32'(log_key[base+1]), 32'hE270);
        check("bp_valid_off", 32'(bus.req_valid),   32'd0);
        wait_log(base + 3, 50, "bp_third_to");
        check("bp_third_key", 32'(log_key[base+2]), 32'h7138);

        // Early full after two adds forces the drain
        do_reset();
        base  = log_n;
        start = 1'b1;
        wait_log(base + 2, 50, "ef_adds_to");
        full  = 1'b1;
        start = 1'b0;
        wait_idle(100, "ef_idle_to");
        check("ef_count", 32'(log_n - base),    32'd4);
        check("ef_op2",   32'(log_op[base+2]),  32'd1);
        check("ef_op3",   32'(log_op[base+3]),  32'd1);
        check("ef_key3",  32'(log_key[base+3]), 32'd0);
        check("ef_fill",  32'(fill_cnt),        32'd0);
        check("ef_round", 32'(round_cnt),       32'd1);
        full = 1'b0;

        // start dropped mid-fill: round finishes then parks
        do_reset();
        base  = log_n;
        start = 1'b1;
        wait_log(base + 1, 50, "sd_first_to");
        start = 1'b0;
        wait_idle(200, "sd_idle_to");
        check("sd_count", 32'(log_n - base),   32'd8);
        check("sd_op3",   32'(log_op[base+3]), 32'd0);
        check("sd_op4",   32'(log_op[base+4]), 32'd1);
        check("sd_op7",   32'(log_op[base+7]), 32'd1);
        check("sd_round", 32'(round_cnt),      32'd1);
        check("sd_state", 32'(dut.state_q),    32'(IDLE));
        repeat (5) @(negedge clk);
        check("sd_parked", 32'(log_n - base),   32'd8);
        check("sd_valid",  32'(bus.req_valid),  32'd0);
        check("sd_busy",   32'(busy),           32'd0);

        // Asynchronous reset with a stalled request
        do_reset();
        ready = 1'b0;
        start = 1'b1;
        wait_valid(50, "ar_valid_to");
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_drop", 32'(bus.req_valid), 32'd0);
        check("ar_busy_drop",  32'(busy),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ar_fill", 32'(fill_cnt), 32'd0);
        base  = log_n;
        ready = 1'b1;
        wait_log(base + 1, 50, "ar_first_to");
        check("ar_key", 32'(log_key[base]), 32'hACE1);
        check("ar_op",  32'(log_op[base]),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pq_req_gen.md
Name: pq_req_gen

Overview:
- Upstream stimulus stage for the priority-queue core; it generates the add and remove requests the queue consumes.
- Produces pseudo-random 16-bit keys from a Galois LFSR and issues them as add requests until the queue is full (or DEPTH adds are done).
- Then issues remove requests until the queue is empty, and repeats while start is held.
- Uses a valid/ready handshake toward the queue and reads the queue's full/empty status.

Parameters:
- KEY_W, 16, key width; the LFSR is fixed at 16 bits, so KEY_W must be 16.
- DEPTH, 16, queue capacity; maximum adds per fill phase.
- GAP_CYCLES, 2, idle cycles inserted after every accepted request; 0 means back-to-back.
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; high runs fill/drain rounds, low parks in IDLE at the end of the current round.
- pq_full  in  1  queue full flag.
- pq_empty  in  1  queue empty flag.
- req_ready  in  1  queue accepts the request this cycle.
- req_valid  out  1  request present.
- req_op  out  1  0 = add, 1 = remove.
- req_key  out  16  key for an add; 16'h0000 for a remove.
- busy  out  1  high in any state other than IDLE.
- fill_cnt  out  $clog2(DEPTH+1)  number of entries this block believes are in the queue.
- round_cnt  out  8  completed fill+drain rounds; wraps 255 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, lfsr=LFSR_SEED, req_valid=0, req_op=0, req_key=0, busy=0, fill_cnt=0, round_cnt=0, gap counter=0. All outputs are registered.
- LFSR: Galois, right shift, taps 16'hB400. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only on an accepted add, so key sequence = seed, then successors.
- Handshake: a transfer occurs on a cycle with req_valid & req_ready. Once req_valid is high, req_valid, req_op and req_key hold stable until that transfer. Status inputs never withdraw a pending request.
- States:
  - IDLE: when start=1, go to FILL_CHK next cycle.
  - FILL_CHK: pq_full=1 or fill_cnt==DEPTH -> DRAIN_CHK. Otherwise register req_valid=1, req_op=0, req_key=lfsr, then go to FILL.
  - FILL: on transfer, req_valid=0, fill_cnt+1, LFSR advances, then go to FILL_GAP.
  - FILL_GAP: count GAP_CYCLES, then go to FILL_CHK. GAP_CYCLES=0 goes straight to FILL_CHK.
  - DRAIN_CHK: pq_empty=1 or fill_cnt==0 -> round_cnt+1, then FILL_CHK if start=1, else IDLE. Otherwise register req_valid=1, req_op=1, req_key=0, then go to DRAIN.
  - DRAIN: on transfer, req_valid=0, fill_cnt-1, then go to DRAIN_GAP.
  - DRAIN_GAP: count GAP_CYCLES, then go to DRAIN_CHK.
- Latency: from start rising in IDLE, first req_valid appears 2 cycles later. Minimum spacing between transfers is 2+GAP_CYCLES cycles.
- Status precedence: pq_full and pq_empty are sampled only in the *_CHK states.
  - A full flag that disagrees with fill_cnt still forces the drain.
  - An empty flag still ends the drain, and fill_cnt is cleared to 0.
- fill_cnt saturates: it never exceeds DEPTH and never drops below 0.
- start deasserted mid-round: the round completes (fill and drain), then the block returns to IDLE.
- Reset mid-transfer: req_valid drops immediately and the LFSR reseeds, so the key sequence restarts.

Decomposition:
- Package pq_pkg holds:
  - enum pq_op_t {PQ_ADD=1'b0, PQ_REMOVE=1'b1};
  - enum gen_state_t with the seven states;
  - localparam LFSR_TAPS=16'hB400;
  - localparam LFSR_SEED_DEF=16'hACE1.
- Sub-module pq_lfsr16 (inputs clk, rst_n, adv, seed; output value) holds the LFSR and the zero-seed guard. The FSM, counters and handshake stay in pq_req_gen.

Test Plan:
1. Basic fill. DEPTH=4, GAP_CYCLES=2, req_ready=1, start=1 after reset. Required: 4 add transfers with keys 16'hACE1, 16'hE270, 16'h7138, 16'h389C; fill_cnt reaches 4; consecutive transfers are 4 cycles apart.
2. Drain and loop. Continue test 1 with pq_empty tied to (fill_cnt==0). Required: 4 remove transfers with req_key=0; round_cnt=1; the next add key is 16'h1C4E.
3. Backpressure. Hold req_ready=0 for 5 cycles during the second add. Required: req_valid stays 1 and req_key stays 16'hE270 throughout; the transfer occurs on the first ready cycle; the LFSR advances exactly once.
4. Early full. Assert pq_full after 2 adds with DEPTH=4. Required: no third add is issued; the block moves to DRAIN_CHK and issues 2 removes.
5. start dropped mid-fill. Required: the fill completes, the drain completes, busy=0, state is IDLE, round_cnt is incremented.
6. Asynchronous reset while req_valid=1 and req_ready=0. Required: req_valid drops with no clock edge; after release and start=1, the first key is 16'hACE1 again and fill_cnt=0.
